// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Optional parity support is enabled with the UART_RX_PARITY_EN macro.
package uart_pkg;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_BAUD_DIV_DEFAULT = 104;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
    , PARITY = 3'd5
`endif
  } rx_state_e;

  // Width of a counter that must reach div-1; never narrower than one bit.
  function automatic int baud_cnt_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin plus falling-edge detect.
// Reset value is line-idle (1) so leaving reset never fakes a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic rx_p;

  // NOTE: sequential state uses non-blocking assignments so each flop samples the pre-edge value of the one before it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
      rx_p <= rx_s;
    end
  end

  assign fall = rx_p & ~rx_s;

endmodule

// File: rtl/uart_rx_data.sv
// UART receive controller: 8N1 framing, mid-bit sampling, holding register with valid/ack handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_data
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      rx,
  input  logic                      rd_ack,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      parity_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = baud_cnt_width(BAUD_DIV);

  localparam logic [CNT_W-1:0] HALF_LIM = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  rx_state_e                 state, state_d;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      rx_s, fall;
  logic                      half_hit, full_hit;
  logic                      cnt_clr, shift_en, deliver, ferr_d, par_ok;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign half_hit = (cnt == HALF_LIM);
  assign full_hit = (cnt == FULL_LIM);
  assign busy     = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bad, perr_d;
  assign par_ok = ~par_bad;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    deliver  = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d   = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (fall) state_d = START;
      end
      START: begin
        if (half_hit) begin
          cnt_clr = 1'b1;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_hit) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == LAST_BIT) state_d = PARITY;
`else
          if (bit_idx == LAST_BIT) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (full_hit) begin
          cnt_clr = 1'b1;
          perr_d  = (^shreg) ^ rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (full_hit) begin
          cnt_clr = 1'b1;
          // A parity failure already flagged the frame; just drop it at stop time.
          if (!par_ok) begin
            state_d = IDLE;
          end else if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_clr = 1'b1;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  // NOTE: every datapath flop, the shift register included, takes the reset so an abandoned frame leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= ferr_d;
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;

      if (state == START)                       bit_idx <= '0;
      else if (shift_en && bit_idx != LAST_BIT) bit_idx <= bit_idx + 3'd1;

      if (shift_en) shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};

      // A new byte wins over a same-cycle acknowledge; without an ack it is dropped.
      if (deliver) begin
        if (!valid) begin
          data  <= shreg;
          valid <= 1'b1;
        end else if (rd_ack) begin
          data  <= shreg;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && rd_ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_d;
      if (state == START) par_bad <= 1'b0;
      else if (perr_d)    par_bad <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_data.sv
// Self-checking bench for uart_rx_data at BAUD_DIV=8: directed timing sequences,
// a table of frame vectors and randomized frames against a frame-level holding-register model.
module tb_uart_rx_data;

  localparam int BD = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // rx driven low after edge n gives the start edge cycle T = n+2; valid is seen T+HALF+(9+PAR)*BD+1.
  localparam int V_AT = 2 + BD / 2 + (9 + PAR) * BD + 1;

  logic       clk = 1'b0;
  logic       rstn, rx, rd_ack;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, overrun, busy;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0, perr_cnt = 0, both_cnt = 0;
  int exp_ferr = 0, exp_perr = 0;

  uart_rx_data #(.BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .rd_ack     (rd_ack),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (parity_err === 1'b1) perr_cnt++;
    if (frame_err === 1'b1 && parity_err === 1'b1) both_cnt++;
  end

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       ack_after;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ovr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
  endtask

  // Drives start, data LSB first, optional even-parity bit, stop; stops early after max_cyc cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_good, input int max_cyc);
    logic [10:0] bits;
    int c;
    c = 0;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    if (PAR == 1) bits[9] = par_good ? ^b : ~^b;
    bits[9 + PAR] = stop;
    for (int i = 0; i < 10 + PAR; i++) begin
      rx = bits[i];
      for (int j = 0; j < BD; j++) begin
        if (c == max_cyc) return;
        step();
        c++;
      end
    end
  endtask

  int         busy_bad, valid_bad, gap;
  logic [7:0] rb, m_data;
  logic       rstop, rpar, m_valid, m_ovr;

  initial begin
    rstn = 1'b0; rx = 1'b1; rd_ack = 1'b0;
    repeat (3) step();
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    rstn = 1'b1;
    idle(4);

    // 1: exact latency of a good frame and the busy window.
    busy_bad = -1; valid_bad = -1;
    fork
      send_frame(8'hA5, 1'b1, 1'b1, 1000);
      begin
        for (int k = 1; k <= V_AT; k++) begin
          step();
          if (busy_bad < 0 && busy !== ((k >= 3 && k < V_AT) ? 1'b1 : 1'b0)) busy_bad = k;
          if (valid_bad < 0 && valid !== ((k >= V_AT) ? 1'b1 : 1'b0)) valid_bad = k;
        end
        check("t1_data", data, 8'hA5);
        check("t1_overrun", overrun, 0);
      end
    join
    check("t1_busy_first_bad_cycle", busy_bad, -1);
    check("t1_valid_first_bad_cycle", valid_bad, -1);
    idle(4);
    check("t1_frame_err_count", ferr_cnt, exp_ferr);
    ack_pulse();
    check("t1_ack_clears_valid", valid, 0);

    // 2: two-cycle glitch is rejected at the start-bit mid-sample.
    rx = 1'b0;
    step(); step();
    rx = 1'b1;
    repeat (4) step();
    check("t2_busy_at_T4", busy, 1);
    step();
    check("t2_busy_at_T5", busy, 0);
    check("t2_no_valid", valid, 0);
    idle(4);
    send_frame(8'h3C, 1'b1, 1'b1, 1000);
    idle(8);
    check("t2_valid", valid, 1);
    check("t2_data", data, 8'h3C);
    check("t2_frame_err_count", ferr_cnt, exp_ferr);
    ack_pulse();

    // 3: bad stop bit followed by a held break.
    send_frame(8'h3C, 1'b0, 1'b1, 1000);
    exp_ferr++;
    repeat (30) step();
    check("t3_frame_err_count", ferr_cnt, exp_ferr);
    check("t3_no_valid", valid, 0);
    check("t3_busy_in_break", busy, 1);
    rx = 1'b1;
    step(); step();
    check("t3_busy_before_release", busy, 1);
    step();
    check("t3_idle_after_release", busy, 0);
    idle(4);

    // 4: back-to-back frames without ack; second one is dropped.
    send_frame(8'h11, 1'b1, 1'b1, 1000);
    send_frame(8'h22, 1'b1, 1'b1, 1000);
    idle(8);
    check("t4_data", data, 8'h11);
    check("t4_valid", valid, 1);
    check("t4_overrun", overrun, 1);
    ack_pulse();
    check("t4_ack_valid", valid, 0);
    check("t4_ack_overrun", overrun, 0);

    // 5: ack lands exactly in the delivery cycle.
    send_frame(8'h11, 1'b1, 1'b1, 1000);
    idle(8);
    fork
      send_frame(8'h22, 1'b1, 1'b1, 1000);
      begin
        repeat (V_AT - 1) step();
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        check("t5_data", data, 8'h22);
        check("t5_valid", valid, 1);
        check("t5_overrun", overrun, 0);
      end
    join
    idle(4);

    // 6: reset in the middle of bit 3 abandons the frame.
    send_frame(8'h55, 1'b1, 1'b1, 4 * BD + BD / 2);
    rstn = 1'b0;
    rx = 1'b1;
    step();
    rstn = 1'b1;
    check("t6_rst_valid", valid, 0);
    check("t6_rst_data", data, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_frame_err", frame_err, 0);
    idle(6);
    check("t6_no_partial_byte", valid, 0);
    send_frame(8'h0F, 1'b1, 1'b1, 1000);
    idle(8);
    check("t6_valid", valid, 1);
    check("t6_data", data, 8'h0F);
    check("t6_frame_err_count", ferr_cnt, exp_ferr);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h0F, 1'b1, 1'b0, 1000);
    exp_perr++;
    idle(8);
    check("par_err_count", perr_cnt, exp_perr);
    check("par_no_valid", valid, 0);
    check("par_no_frame_err", ferr_cnt, exp_ferr);
`endif

    // Table of frame vectors, applied in order from valid=0.
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[2] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h81, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].b, vecs[i].stop, 1'b1, 1000);
      idle(8);
      if (vecs[i].exp_ferr) exp_ferr++;
      check($sformatf("tbl%0d_valid", i), valid, vecs[i].exp_valid);
      check($sformatf("tbl%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("tbl%0d_overrun", i), overrun, vecs[i].exp_ovr);
      check($sformatf("tbl%0d_frame_err_count", i), ferr_cnt, exp_ferr);
      if (vecs[i].ack_after) ack_pulse();
    end

    // Random frames against a frame-level model of the holding register.
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = vecs[6].exp_data;
    for (int r = 0; r < 24; r++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 5) != 0);
      rpar  = (PAR == 1) ? ($urandom_range(0, 4) != 0) : 1'b1;
      send_frame(rb, rstop, rpar, 1000);
      if (!rpar) exp_perr++;
      else if (!rstop) exp_ferr++;
      else if (!m_valid) begin
        m_data  = rb;
        m_valid = 1'b1;
      end else m_ovr = 1'b1;
      gap = $urandom_range(4, 12);
      idle(gap);
      check($sformatf("rnd%0d_valid", r), valid, m_valid);
      check($sformatf("rnd%0d_data", r), data, m_data);
      check($sformatf("rnd%0d_overrun", r), overrun, m_ovr);
      check($sformatf("rnd%0d_frame_err_count", r), ferr_cnt, exp_ferr);
      check($sformatf("rnd%0d_parity_err_count", r), perr_cnt, exp_perr);
      if ($urandom_range(0, 2) == 0) begin
        ack_pulse();
        if (m_valid) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
      end
    end

    check("final_parity_err_count", perr_cnt, exp_perr);
    check("final_err_pulses_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
